traffic_light_controller: RTL and testbench
===========================================

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Clock and reset SHALL be one clock with asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter T_MAIN, default 7, SHALL set the S1 dwell: mains green, in clk cycles.
REQ-003 Parameter T_M2Y, default 2, SHALL set the S2 dwell: M2 yellow.
REQ-004 Parameter T_MT, default 5, SHALL set the S3 dwell: main-turn green.
REQ-005 Parameter T_MY, default 2, SHALL set the S4 dwell: M1 and MT yellow.
REQ-006 Parameter T_SIDE, default 3, SHALL set the S5 dwell: side green.
REQ-007 Parameter T_SY, default 2, SHALL set the S6 dwell: side yellow.
REQ-008 Parameter T_AR, default 1, SHALL set the all-red dwell; it is used only with TLC_ALL_RED_EN.
REQ-009 Port clk, input, width 1, SHALL be the rising-edge clock.
REQ-010 Port rst, input, width 1, SHALL be the asynchronous active-high reset.
REQ-011 Port M1, output, width 3, SHALL drive the main road direction 1 lamp.
REQ-012 Port MT, output, width 3, SHALL drive the main road turn lamp.
REQ-013 Port M2, output, width 3, SHALL drive the main road direction 2 lamp.
REQ-014 Port S, output, width 3, SHALL drive the side road lamp.
REQ-015 Lamp encoding SHALL be one-hot:
- 3'b001 = GREEN
- 3'b010 = YELLOW
- 3'b100 = RED
- 3'b000 = OFF, never driven

Function
REQ-016 The block SHALL be a Moore FSM; outputs SHALL decode from the state register only, with no input-to-output path.
REQ-017 States and lamps (M1/M2/MT/S) SHALL be:
- S1: G/G/R/R
- S2: G/Y/R/R
- S3: G/R/G/R
- S4: Y/R/Y/R
- S5: R/R/R/G
- S6: R/R/R/Y
REQ-018 Transition order SHALL be S1->S2->S3->S4->S5->S6->S1, repeating indefinitely.
REQ-019 Dwell timing SHALL use an 8-bit cycle counter:
- counter clears on every state entry and increments each clk;
- the state advances on the edge where counter == T_x-1.
REQ-020 Each state SHALL therefore last exactly T_x cycles; the default full cycle is 21 cycles.
REQ-021 A parameter value of 0 SHALL behave as 1; legal range is 1..255.
REQ-022 Safety invariants SHALL hold in every cycle:
- S non-red only when M1, M2 and MT are all red;
- MT non-red only when M2 is red;
- exactly one bit set on every lamp.
REQ-023 Unreachable state encodings SHALL recover to S1 with the counter at 0 on the next clk.

Reset
REQ-024 When rst=1, state and counter SHALL asynchronously go to S1 and 0.
REQ-025 During reset, outputs SHALL be M1=001, M2=001, MT=100, S=100.
REQ-026 After rst deassertion, S1 SHALL last a full T_MAIN cycles.
REQ-027 Reset asserted mid-sequence SHALL abort immediately to S1, with no yellow phase.

Configuration
REQ-028 Macro TLC_ALL_RED_EN defined SHALL insert state AR, all four lamps 3'b100, lasting T_AR cycles, between S6 and S1; the default cycle becomes 22.
REQ-029 Macro TLC_ALL_RED_EN undefined SHALL make S6 go directly to S1, with no AR state or logic.

Verification
REQ-030 Reset: rst=1 for 2 cycles -> M1=001, M2=001, MT=100, S=100 both during and immediately after reset.
REQ-031 Default sequence: release rst, run 120 cycles ->
- lamp sequence S1 7, S2 2, S3 5, S4 2, S5 3, S6 2 cycles;
- period 21 cycles, 22 with TLC_ALL_RED_EN.
REQ-032 Invariants: checker samples every cycle over 120+ cycles -> zero violations of REQ-022; no lamp ever 000 or multi-hot.
REQ-033 Mid-run reset: assert rst asynchronously, between clock edges, during S5 -> outputs return to the S1 pattern before the next clk edge; after release, S1 lasts 7 cycles.
REQ-034 Parameter override: all T_x=1 -> state changes every cycle; with the default macro setting, 6-cycle period.
REQ-035 Final reset: rst=1 after 1200 ns of run -> the S1 pattern is held until simulation ends.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Traffic light controller for a main road (two through directions M1/M2
// plus a turn lane MT) crossing a side road S.
// Moore FSM cycling S1..S6; each state dwells T_x clk cycles, timed by an
// 8-bit counter that clears on every state entry.
// Optional macro TLC_ALL_RED_EN inserts an all-red state AR between S6 and S1.
// Lamp encoding is one-hot: 001 green, 010 yellow, 100 red.
module traffic_light_controller #(
  parameter int T_MAIN = 7,
  parameter int T_M2Y  = 2,
  parameter int T_MT   = 5,
  parameter int T_MY   = 2,
  parameter int T_SIDE = 3,
  parameter int T_SY   = 2,
  parameter int T_AR   = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] M1,
  output logic [2:0] MT,
  output logic [2:0] M2,
  output logic [2:0] S
);

  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_R = 3'b100;

  // Lamp word packing is {M1, M2, MT, S}.
  localparam logic [11:0] LAMPS_S1 = {L_G, L_G, L_R, L_R};

  // A dwell of 0 is treated as 1 so every state lasts at least one cycle.
  localparam logic [7:0] D_MAIN = (T_MAIN == 0) ? 8'd1 : 8'(T_MAIN);
  localparam logic [7:0] D_M2Y  = (T_M2Y  == 0) ? 8'd1 : 8'(T_M2Y);
  localparam logic [7:0] D_MT   = (T_MT   == 0) ? 8'd1 : 8'(T_MT);
  localparam logic [7:0] D_MY   = (T_MY   == 0) ? 8'd1 : 8'(T_MY);
  localparam logic [7:0] D_SIDE = (T_SIDE == 0) ? 8'd1 : 8'(T_SIDE);
  localparam logic [7:0] D_SY   = (T_SY   == 0) ? 8'd1 : 8'(T_SY);

`ifdef TLC_ALL_RED_EN
  localparam logic [7:0] D_AR   = (T_AR   == 0) ? 8'd1 : 8'(T_AR);

  typedef enum logic [2:0] {
    ST_S1 = 3'd0,
    ST_S2 = 3'd1,
    ST_S3 = 3'd2,
    ST_S4 = 3'd3,
    ST_S5 = 3'd4,
    ST_S6 = 3'd5,
    ST_AR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_S1 = 3'd0,
    ST_S2 = 3'd1,
    ST_S3 = 3'd2,
    ST_S4 = 3'd3,
    ST_S5 = 3'd4,
    ST_S6 = 3'd5
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] lamps_q;

  state_t      nxt;
  logic [7:0]  dwell;
  logic        illegal;
  logic        advance;

  // Lamp pattern shown while in a given state.
  function automatic logic [11:0] lamps_of(input state_t st);
    case (st)
      ST_S1:   lamps_of = {L_G, L_G, L_R, L_R};
      ST_S2:   lamps_of = {L_G, L_Y, L_R, L_R};
      ST_S3:   lamps_of = {L_G, L_R, L_G, L_R};
      ST_S4:   lamps_of = {L_Y, L_R, L_Y, L_R};
      ST_S5:   lamps_of = {L_R, L_R, L_R, L_G};
      ST_S6:   lamps_of = {L_R, L_R, L_R, L_Y};
`ifdef TLC_ALL_RED_EN
      ST_AR:   lamps_of = {L_R, L_R, L_R, L_R};
`endif
      default: lamps_of = LAMPS_S1;
    endcase
  endfunction

  // Next-state and dwell selection; unused encodings fall back to S1.
  always_comb begin
    nxt     = ST_S1;
    dwell   = D_MAIN;
    illegal = 1'b0;
    case (state_q)
      ST_S1: begin dwell = D_MAIN; nxt = ST_S2; end
      ST_S2: begin dwell = D_M2Y;  nxt = ST_S3; end
      ST_S3: begin dwell = D_MT;   nxt = ST_S4; end
      ST_S4: begin dwell = D_MY;   nxt = ST_S5; end
      ST_S5: begin dwell = D_SIDE; nxt = ST_S6; end
`ifdef TLC_ALL_RED_EN
      ST_S6: begin dwell = D_SY;   nxt = ST_AR; end
      ST_AR: begin dwell = D_AR;   nxt = ST_S1; end
`else
      ST_S6: begin dwell = D_SY;   nxt = ST_S1; end
`endif
      default: begin dwell = 8'd1; nxt = ST_S1; illegal = 1'b1; end
    endcase
    advance = illegal || (cnt_q == dwell - 8'd1);
    state_d = advance ? nxt : state_q;
    cnt_d   = advance ? 8'd0 : cnt_q + 8'd1;
  end

  // State, dwell counter and registered lamps; reset forces S1 at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_S1;
      cnt_q   <= 8'd0;
      lamps_q <= LAMPS_S1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamps_q <= lamps_of(state_d);
    end
  end

  assign {M1, M2, MT, S} = lamps_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: a default-parameter instance and an
// all-dwells-1 instance, checked against an expected-lamp queue.
module tb_traffic_light_controller;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] m1, mt, m2, s;
  logic [2:0] m1b, mtb, m2b, sb;

  traffic_light_controller dut (
    .clk(clk), .rst(rst), .M1(m1), .MT(mt), .M2(m2), .S(s)
  );

  traffic_light_controller #(
    .T_MAIN(1), .T_M2Y(1), .T_MT(1), .T_MY(1), .T_SIDE(1), .T_SY(1), .T_AR(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .M1(m1b), .MT(mtb), .M2(m2b), .S(sb)
  );

  // ---------------- model ----------------
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [11:0] P_S1 = {G, G, R, R};
  localparam logic [11:0] P_S6 = {R, R, R, Y};

`ifdef TLC_ALL_RED_EN
  localparam int NST = 7;
`else
  localparam int NST = 6;
`endif

  int dwell_def[7] = '{7, 2, 5, 2, 3, 2, 1};
  int dwell_one[7] = '{1, 1, 1, 1, 1, 1, 1};
  int period_def;

  logic [11:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Lamp pattern {M1,M2,MT,S} for state index 0..6 (6 = all red).
  function automatic logic [11:0] pat_of(input int st);
    case (st)
      0: pat_of = {G, G, R, R};
      1: pat_of = {G, Y, R, R};
      2: pat_of = {G, R, G, R};
      3: pat_of = {Y, R, Y, R};
      4: pat_of = {R, R, R, G};
      5: pat_of = {R, R, R, Y};
      default: pat_of = {R, R, R, R};
    endcase
  endfunction

  // Push one full light cycle of expected per-cycle lamp words.
  task automatic push_period(input int d[7]);
    for (int st = 0; st < NST; st++)
      for (int k = 0; k < d[st]; k++)
        exp_q.push_back(pat_of(st));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      obs = {m1, m2, mt, s};
      total++;
      if (obs !== P_S1) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, P_S1);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    obs = {m1, m2, mt, s};
    total++;
    if (obs !== P_S1) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", obs, P_S1);
    end
  endtask

  task automatic test_sequence();
    logic [11:0] obs, exp, prev;
    int n, last_entry;
    logic inv_ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 6 * period_def;
    for (int p = 0; p < 6; p++) push_period(dwell_def);
    prev = P_S1;
    last_entry = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      obs = {m1, m2, mt, s};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL seq_queue_empty idx=%0d got=%h", i, obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          bad++;
          $display("FAIL seq idx=%0d got=%h want=%h", i, obs, exp);
        end
      end
      inv_ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s) &&
               (s == R || (m1 == R && m2 == R && mt == R)) &&
               (mt == R || m2 == R);
      total++;
      if (inv_ok !== 1'b1) begin
        bad++;
        $display("FAIL invariant idx=%0d got=%h want=safe", i, obs);
      end
      if (i > 0 && obs === P_S1 && prev !== P_S1) begin
        total++;
        if (i - last_entry !== period_def) begin
          bad++;
          $display("FAIL period idx=%0d got=%0d want=%0d", i, i - last_entry, period_def);
        end
        last_entry = i;
      end
      prev = obs;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] obs, exp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    push_period(dwell_def);
    // Run up to the first cycle of S5 (index 16).
    for (int i = 0; i < 17; i++) begin
      #1;
      obs = {m1, m2, mt, s};
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL midrst_pre idx=%0d got=%h want=%h", i, obs, exp);
      end
      @(negedge clk);
    end
    exp_q.delete();
    // Assert reset between edges while in S5.
    #2;
    rst = 1'b1;
    #1;
    obs = {m1, m2, mt, s};
    total++;
    if (obs !== P_S1) begin
      bad++;
      $display("FAIL midrst_async got=%h want=%h", obs, P_S1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) exp_q.push_back(pat_of(0));
    exp_q.push_back(pat_of(1));
    for (int i = 0; i < 8; i++) begin
      #1;
      obs = {m1, m2, mt, s};
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL midrst_post idx=%0d got=%h want=%h", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_param_one();
    logic [11:0] obs, exp, prev;
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    exp_q.delete();
    push_period(dwell_one);
    push_period(dwell_one);
    prev = 12'h000;
    for (int i = 0; i < 2 * NST; i++) begin
      #1;
      obs = {m1b, m2b, mtb, sb};
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL one_seq idx=%0d got=%h want=%h", i, obs, exp);
      end
      if (i > 0) begin
        total++;
        if (obs === prev) begin
          bad++;
          $display("FAIL one_change idx=%0d got=%h want=not_%h", i, obs, prev);
        end
      end
      prev = obs;
      @(negedge clk);
    end
  endtask

  task automatic test_final_reset();
    logic [11:0] obs, obsb;
    while ($time < 1200) @(negedge clk);
    #2;
    rst  = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      obs  = {m1, m2, mt, s};
      obsb = {m1b, m2b, mtb, sb};
      total++;
      if (obs !== P_S1 || obsb !== P_S1) begin
        bad++;
        $display("FAIL final_reset idx=%0d got=%h/%h want=%h", i, obs, obsb, P_S1);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    period_def = 0;
    for (int st = 0; st < NST; st++) period_def += dwell_def[st];
    test_reset();
    test_sequence();
    test_mid_reset();
    test_param_one();
    test_final_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
